// File: rtl/tank_pkg.sv
// Shared tank-game constants: direction codes and button indices.
// Also holds the direction priority helpers used by the button front end.
package tank_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int BTN_W  = 0;
    localparam int BTN_A  = 1;
    localparam int BTN_S  = 2;
    localparam int BTN_D  = 3;
    localparam int BTN_ST = 4;
    localparam int NBTN   = 5;

    // Fixed priority w > s > a > d over a direction-button mask.
    function automatic logic [1:0] prio_dir(input logic [3:0] m);
        if (m[BTN_W]) return DIR_UP;
        if (m[BTN_S]) return DIR_DOWN;
        if (m[BTN_A]) return DIR_LEFT;
        return DIR_RIGHT;
    endfunction

    function automatic logic [1:0] dir_btn(input logic [1:0] d);
        logic [1:0] b;
        b = 2'(BTN_D);
        unique case (d)
            DIR_UP:    b = 2'(BTN_W);
            DIR_DOWN:  b = 2'(BTN_S);
            DIR_LEFT:  b = 2'(BTN_A);
            DIR_RIGHT: b = 2'(BTN_D);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, stability counter, debounced level
// and registered rise strobe. Next-state values are exported for the top.
module debounce_cell #(
    parameter int DEB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic db_o,
    output logic rise_o,
    output logic db_d_o,
    output logic rise_d_o
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = db_d & ~db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= pad_i;
            sync_q <= meta_q;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
        end
    end

    assign db_o     = db_q;
    assign rise_o   = rise_q;
    assign db_d_o   = db_d;
    assign rise_d_o = rise_d;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: debounce five pads, derive move direction
// with most-recent-press priority, and generate shoot / auto-fire strobes.
module btn_conditioner
    import tank_pkg::*;
#(
    parameter int DEB_CYCLES  = 2_000_000,
    parameter int FIRE_REPEAT = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bt_w,
    input  logic       bt_a,
    input  logic       bt_s,
    input  logic       bt_d,
    input  logic       bt_st,
    output logic [4:0] db_level,
    output logic [4:0] press_pulse,
    output logic [1:0] move_dir,
    output logic       move_valid,
    output logic       shoot
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    localparam int TW = (FIRE_REPEAT > 1) ? $clog2(FIRE_REPEAT) : 1;
    localparam logic AF_EN = (FIRE_REPEAT > 0);
    localparam logic [TW-1:0] TMAX =
        TW'((FIRE_REPEAT > 0) ? FIRE_REPEAT - 1 : 0);

    logic [4:0]    pads;
    logic [4:0]    db_d;
    logic [4:0]    rise_d;
    logic [0:0]    state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          shoot_q, shoot_d;
    logic          fire;

    assign pads = {bt_st, bt_d, bt_s, bt_a, bt_w};

    for (genvar i = 0; i < NBTN; i++) begin : g_cell
        debounce_cell #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad_i   (pads[i]),
            .db_o    (db_level[i]),
            .rise_o  (press_pulse[i]),
            .db_d_o  (db_d[i]),
            .rise_d_o(rise_d[i])
        );
    end

    // Decisions use next-state levels so direction tracks db_level
    // on the same edge.
    always_comb begin
        dir_d = dir_q;
        if (|rise_d[3:0]) begin
            dir_d = prio_dir(rise_d[3:0]);
        end else if (state_q == S_HELD && !db_d[dir_btn(dir_q)]
                     && |db_d[3:0]) begin
            dir_d = prio_dir(db_d[3:0]);
        end
        state_d = (|db_d[3:0]) ? S_HELD : S_IDLE;
    end

    always_comb begin
        timer_d = '0;
        fire    = 1'b0;
        if (AF_EN && db_q_st() && db_d[BTN_ST]) begin
            if (timer_q == TMAX) begin
                fire = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        shoot_d = rise_d[BTN_ST] | fire;
    end

    function automatic logic db_q_st();
        return db_level[BTN_ST];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            timer_q <= '0;
            shoot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            shoot_q <= shoot_d;
        end
    end

    assign move_dir   = dir_q;
    assign move_valid = (state_q == S_HELD);
    assign shoot      = shoot_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed checks of btn_conditioner against a
// sample-history reference model (DEB_CYCLES=4, FIRE_REPEAT=8).
module tb_btn_conditioner;

    localparam int DEB = 4;
    localparam int FR  = 8;

    logic       clk;
    logic       rst_n;
    logic [4:0] pad;
    logic [4:0] db_level;
    logic [4:0] press_pulse;
    logic [1:0] move_dir;
    logic       move_valid;
    logic       shoot;

    int n_cmp;
    int n_bad;

    btn_conditioner #(
        .DEB_CYCLES (DEB),
        .FIRE_REPEAT(FR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bt_w       (pad[0]),
        .bt_a       (pad[1]),
        .bt_s       (pad[2]),
        .bt_d       (pad[3]),
        .bt_st      (pad[4]),
        .db_level   (db_level),
        .press_pulse(press_pulse),
        .move_dir   (move_dir),
        .move_valid (move_valid),
        .shoot      (shoot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [4:0]     m_p1, m_p2;
    logic [4:0]     m_db, m_pp;
    logic [DEB-1:0] m_hist[5];
    int             m_run[5];
    logic [1:0]     m_dir;
    logic           m_valid, m_shoot;
    int             m_cyc, m_t0;

    // button index -> direction code, and the reverse
    int b2c[4] = '{0, 2, 1, 3};
    int c2b[4] = '{0, 2, 1, 3};
    int ord[4] = '{0, 2, 1, 3};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_db = '0; m_pp = '0;
        for (int i = 0; i < 5; i++) begin
            m_hist[i] = '0;
            m_run[i]  = 0;
        end
        m_dir = 2'b00; m_valid = 1'b0; m_shoot = 1'b0;
        m_t0 = 0;
    endtask

    function automatic int first_of(input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[ord[k]]) return ord[k];
        return -1;
    endfunction

    // Level flips once the last DEB synchronised samples since the
    // previous flip all disagree with it.
    task automatic model_edge();
        logic [4:0] seen, nd, r;
        int own;
        seen = m_p2;
        m_p2 = m_p1;
        m_p1 = pad;
        nd = m_db;
        for (int i = 0; i < 5; i++) begin
            m_hist[i] = {m_hist[i][DEB-2:0], seen[i]};
            if (m_run[i] < DEB) m_run[i]++;
            if (m_run[i] >= DEB &&
                m_hist[i] == (m_db[i] ? {DEB{1'b0}} : {DEB{1'b1}})) begin
                nd[i] = ~m_db[i];
                m_run[i] = 0;
            end
        end
        r = nd & ~m_db;
        own = c2b[m_dir];
        if (r[3:0] != 0)
            m_dir = 2'(b2c[first_of(r[3:0])]);
        else if (!nd[own] && nd[3:0] != 0)
            m_dir = 2'(b2c[first_of(nd[3:0])]);
        m_valid = |nd[3:0];
        m_shoot = 1'b0;
        if (r[4]) begin
            m_shoot = 1'b1;
            m_t0 = m_cyc;
        end else if (m_db[4] && nd[4] && ((m_cyc - m_t0) % FR) == 0) begin
            m_shoot = 1'b1;
        end
        m_pp = r;
        m_db = nd;
    endtask

    task automatic cmp_all();
        chk("db_level", 32'(db_level), 32'(m_db));
        chk("press_pulse", 32'(press_pulse), 32'(m_pp));
        chk("move_dir", 32'(move_dir), 32'(m_dir));
        chk("move_valid", 32'(move_valid), 32'(m_valid));
        chk("shoot", 32'(shoot), 32'(m_shoot));
    endtask

    task automatic step();
        @(posedge clk);
        m_cyc++;
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        cmp_all();
    endtask

    task automatic wait_bit(input int b, input logic v, output int idx);
        idx = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (db_level[b] == v) begin
                idx = k;
                break;
            end
        end
    endtask

    task automatic hold_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    int idx, shots;
    logic [31:0] mask;

    initial begin
        n_cmp = 0; n_bad = 0; m_cyc = 0;
        pad = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_db", 32'(db_level), 0);
        chk("rst_pp", 32'(press_pulse), 0);
        chk("rst_dir", 32'(move_dir), 0);
        chk("rst_valid", 32'(move_valid), 0);
        chk("rst_shoot", 32'(shoot), 0);

        // w held through reset
        pad[0] = 1'b1;
        step();
        rst_n = 1'b1;
        wait_bit(0, 1'b1, idx);
        chk("w_lat", idx, DEB + 1);
        chk("w_dir", 32'(move_dir), 0);
        pad[0] = 1'b0;
        wait_bit(0, 1'b0, idx);
        chk("w_rel", 32'(move_valid), 0);

        // 3-cycle glitch on a, then a real press
        pad[1] = 1'b1;
        repeat (3) step();
        pad[1] = 1'b0;
        shots = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (db_level[1] || press_pulse[1]) shots++;
        end
        chk("a_glitch", shots, 0);
        pad[1] = 1'b1;
        wait_bit(1, 1'b1, idx);
        chk("a_lat", idx, DEB + 1);
        chk("a_pulse", 32'(press_pulse[1]), 1);
        step();
        chk("a_pulse_end", 32'(press_pulse[1]), 0);
        pad[1] = 1'b0;
        wait_bit(1, 1'b0, idx);

        // w then d, release d, release w
        pad[0] = 1'b1;
        wait_bit(0, 1'b1, idx);
        chk("wd_w", 32'(move_dir), 32'h0);
        pad[3] = 1'b1;
        wait_bit(3, 1'b1, idx);
        chk("wd_d", 32'(move_dir), 32'h3);
        pad[3] = 1'b0;
        wait_bit(3, 1'b0, idx);
        chk("wd_back", 32'(move_dir), 32'h0);
        chk("wd_valid", 32'(move_valid), 1);
        pad[0] = 1'b0;
        wait_bit(0, 1'b0, idx);
        chk("wd_idle", 32'(move_valid), 0);
        chk("wd_keep", 32'(move_dir), 32'h0);

        // s and d together
        pad[2] = 1'b1; pad[3] = 1'b1;
        wait_bit(2, 1'b1, idx);
        chk("sd_dir", 32'(move_dir), 32'h1);
        pad[2] = 1'b0; pad[3] = 1'b0;
        repeat (10) step();

        // auto-fire: strobe offsets 0,8,16,24 from accept
        pad[4] = 1'b1;
        wait_bit(4, 1'b1, idx);
        chk("st_first", 32'(shoot), 1);
        mask = 32'h1; shots = 1;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (shoot) begin
                shots++;
                if (k < 32) mask[k] = 1'b1;
            end
            if (k == 25) pad[4] = 1'b0;
        end
        chk("af_count", shots, 4);
        chk("af_offsets", mask, 32'h01010101);

        // reset in the middle of auto-fire, st held across it
        pad[4] = 1'b1;
        wait_bit(4, 1'b1, idx);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_shoot", 32'(shoot), 0);
        chk("mid_rst_db", 32'(db_level), 0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        wait_bit(4, 1'b1, idx);
        chk("st_relat", idx, DEB + 1);
        pad[4] = 1'b0;
        repeat (10) step();

        // random stimulus with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 5; i++)
                if ($urandom_range(0, 11) == 0) pad[i] = ~pad[i];
            if ($urandom_range(0, 499) == 0) hold_reset(2);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
